// File: rtl/motor_cmd_scheduler_pkg.sv
// Shared types and sizes for the motor command scheduler slice.
package motor_sched_pkg;

  localparam int unsigned NUM_MOTORS = 6;
  localparam int unsigned POS_W      = 10;
  localparam int unsigned PW         = 16;

  typedef logic [2:0] motor_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/motor_cmd_scheduler_if.sv
// Command input bus: one target coordinate per transfer, valid/ready handshake.
interface motor_cmd_scheduler_if;
  import motor_sched_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  motor_idx_t             cmd_motor;
  logic [POS_W-1:0]       cmd_value;

  modport master (output cmd_valid, output cmd_motor, output cmd_value, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_motor, input cmd_value, output cmd_ready);

endinterface

// File: rtl/motor_cmd_scheduler_rr_arbiter6.sv
// Round-robin arbiter over the six channels; search starts one past the last grant.
module rr_arbiter6
  import motor_sched_pkg::*;
(
  input  logic [NUM_MOTORS-1:0] req,
  input  motor_idx_t            ptr,
  output motor_idx_t            gnt_idx,
  output logic                  gnt_vld
);

  // First requester found scanning ptr+1, ptr+2, ... modulo six
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 1; i <= NUM_MOTORS; i++) begin
      idx = (32'(ptr) + i) % NUM_MOTORS;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = motor_idx_t'(idx);
      end
    end
  end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Holds one pending target per motor, dispatches round-robin, converts the move to
// a pulse count/direction and runs the start/busy handshake with each pulse generator.
// Optional build macro: SCHED_COALESCE_EN (always ready, latest target overwrites pending one).
module motor_cmd_scheduler
  import motor_sched_pkg::*;
#(
  parameter int unsigned STEPS_PER_UNIT = 4,
  parameter int unsigned ACK_TO         = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  motor_cmd_scheduler_if.slave     cmd,
  input  logic [NUM_MOTORS-1:0]    init_done,
  input  logic                     lock,
  input  logic [NUM_MOTORS-1:0]    busy,
  output logic [NUM_MOTORS-1:0]    start,
  output logic [NUM_MOTORS*PW-1:0] pulse_num,
  output logic [NUM_MOTORS-1:0]    dir,
  output logic [NUM_MOTORS-1:0]    mf,
  output logic                     err_cmd,
  output logic [NUM_MOTORS-1:0]    err_ack
);

  localparam logic [31:0] PMAX = (32'd1 << PW) - 32'd1;
  localparam int unsigned TW   = $clog2(ACK_TO + 1);

  state_t                state, state_nxt;
  motor_idx_t            g, g_nxt, ptr, ptr_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [POS_W-1:0]      tgt;
  logic [NUM_MOTORS-1:0] slot_full;
  logic [POS_W-1:0]      slot_val [NUM_MOTORS];
  logic [POS_W-1:0]      last     [NUM_MOTORS];

  logic                  idx_ok, accept;
  logic [NUM_MOTORS-1:0] req;
  motor_idx_t            gnt_idx;
  logic                  gnt_vld;
  logic [POS_W-1:0]      cur_val, cur_last, delta;
  logic                  dir_c;
  logic [31:0]           prod;
  logic [PW-1:0]         pcount;
  logic                  clr_slot, latch, issue, ack_ok, ack_err;

  assign idx_ok = (cmd.cmd_motor < motor_idx_t'(NUM_MOTORS));
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign req    = slot_full & init_done & ~busy & ~err_ack;

  // Ready: backpressure per slot; illegal indices are always taken and dropped
  always_comb begin
`ifdef SCHED_COALESCE_EN
    cmd.cmd_ready = 1'b1;
`else
    cmd.cmd_ready = idx_ok ? !slot_full[cmd.cmd_motor] : 1'b1;
`endif
  end

  rr_arbiter6 u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Move magnitude, direction and saturated pulse count for the granted motor
  always_comb begin
    cur_val  = slot_val[g];
    cur_last = last[g];
    dir_c    = (cur_val > cur_last);
    delta    = dir_c ? (cur_val - cur_last) : (cur_last - cur_val);
    prod     = 32'(delta) * STEPS_PER_UNIT;
    pcount   = (prod > PMAX) ? PW'(PMAX) : prod[PW-1:0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= motor_idx_t'(NUM_MOTORS - 1);
      timer <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      ptr   <= ptr_nxt;
      timer <= timer_nxt;
    end
  end

  // FSM next state and per-state control strobes
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    ptr_nxt   = ptr;
    timer_nxt = timer;
    start     = '0;
    clr_slot  = 1'b0;
    latch     = 1'b0;
    issue     = 1'b0;
    ack_ok    = 1'b0;
    ack_err   = 1'b0;
    case (state)
      IDLE: begin
        if (!lock && gnt_vld) begin
          g_nxt     = gnt_idx;
          ptr_nxt   = gnt_idx;
          state_nxt = CALC;
        end
      end
      CALC: begin
`ifdef SCHED_COALESCE_EN
        // Target is captured into tgt here, so the slot is freed now; a command
        // landing in CALC or ISSUE then stays pending as the next move.
        clr_slot = 1'b1;
`else
        clr_slot = (delta == '0);
`endif
        if (delta == '0) begin
          state_nxt = IDLE;
        end else begin
          latch     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        start[g]  = 1'b1;
        issue     = 1'b1;
`ifndef SCHED_COALESCE_EN
        clr_slot  = 1'b1;
`endif
        timer_nxt = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (busy[g]) begin
          ack_ok    = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TW'(ACK_TO)) begin
          ack_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending-target slots: accept sets, dispatch clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= '0;
      for (int unsigned i = 0; i < NUM_MOTORS; i++) slot_val[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
`ifdef SCHED_COALESCE_EN
        if (accept && idx_ok && cmd.cmd_motor == motor_idx_t'(i)) begin
          slot_full[i] <= 1'b1;
          slot_val[i]  <= cmd.cmd_value;
        end else if (clr_slot && g == motor_idx_t'(i)) begin
          slot_full[i] <= 1'b0;
        end
`else
        if (clr_slot && g == motor_idx_t'(i)) begin
          slot_full[i] <= 1'b0;
        end else if (accept && idx_ok && cmd.cmd_motor == motor_idx_t'(i)) begin
          slot_full[i] <= 1'b1;
          slot_val[i]  <= cmd.cmd_value;
        end
`endif
      end
    end
  end

  // Per-motor outputs, last positions and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_num <= '0;
      dir       <= '0;
      mf        <= '0;
      err_ack   <= '0;
      err_cmd   <= 1'b0;
      tgt       <= '0;
      for (int unsigned i = 0; i < NUM_MOTORS; i++) last[i] <= '0;
    end else begin
      err_cmd <= accept && !idx_ok;
      if (latch) begin
        pulse_num[32'(g)*PW +: PW] <= pcount;
        dir[g]                     <= dir_c;
        tgt                        <= cur_val;
      end
      if (issue)   mf[g]      <= 1'b1;
      if (ack_ok)  last[g]    <= tgt;
      if (ack_err) err_ack[g] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler: vector table for single moves plus
// hand-written sequences for arbitration order, timeout, lock, homing and reset.
module tb_motor_cmd_scheduler;
  import motor_sched_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  init_done;
  logic        lock;
  logic [5:0]  busy = 6'b0;
  logic [5:0]  start;
  logic [95:0] pulse_num;
  logic [5:0]  dir;
  logic [5:0]  mf;
  logic        err_cmd;
  logic [5:0]  err_ack;

  logic [5:0]  ack_en;
  logic [5:0]  start_seen;
  int          grants[$];
  int          bcnt[6];
  int          checks;
  int          errors;

  motor_cmd_scheduler_if cif();

  motor_cmd_scheduler #(.STEPS_PER_UNIT(4), .ACK_TO(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .init_done (init_done),
    .lock      (lock),
    .busy      (busy),
    .start     (start),
    .pulse_num (pulse_num),
    .dir       (dir),
    .mf        (mf),
    .err_cmd   (err_cmd),
    .err_ack   (err_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse generator stand-in: acknowledges an enabled start by holding busy 3 cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) bcnt[i] = 0;
      busy = 6'b0;
    end else begin
      #1;
      for (int i = 0; i < 6; i++) begin
        if (bcnt[i] > 0) bcnt[i] = bcnt[i] - 1;
        if (start[i] && ack_en[i]) bcnt[i] = 3;
        busy[i] = (bcnt[i] != 0);
      end
    end
  end

  // Strobe monitor: records grant order and any strobe seen
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 6; i++) begin
      if (start[i] === 1'b1) begin
        grants.push_back(i);
        start_seen[i] = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  m;
    logic [9:0]  v;
    bit          strobe;
    logic [15:0] pn;
    bit          d;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pn_of(input int m);
    return pulse_num[m*16 +: 16];
  endfunction

  // Present a command until accepted (bounded); returns one cycle after the accept edge
  task automatic send(input logic [2:0] m, input logic [9:0] v);
    bit rdy;
    bit ok;
    ok = 1'b0;
    cif.cmd_valid = 1'b1;
    cif.cmd_motor = m;
    cif.cmd_value = v;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      rdy = cif.cmd_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    cif.cmd_valid = 1'b0;
    if (!ok) check("send_accept", 0, 1);
  endtask

  task automatic wait_grant(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      if (grants.size() > 0) got = 1'b1;
      else tick();
    end
    check(name, got, 1);
  endtask

  task automatic run_vec(input vec_t x, input int k);
    logic [5:0] e;
    e = '0;
    if (x.strobe) e[x.m] = 1'b1;
    send(x.m, x.v);
    check($sformatf("v%0d_start_k1", k), start, 0);
    tick();
    check($sformatf("v%0d_start_k2", k), start, 0);
    tick();
    check($sformatf("v%0d_start_k3", k), start, e);
    repeat (6) tick();
    check($sformatf("v%0d_pulse", k), pn_of(x.m), x.pn);
    check($sformatf("v%0d_dir", k), dir[x.m], x.d);
    check($sformatf("v%0d_mf", k), mf[x.m], 1);
  endtask

  initial begin
    logic [5:0] e;
    checks = 0;
    errors = 0;
    tbl[0] = '{m: 3'd0, v: 10'd100,  strobe: 1'b1, pn: 16'd400,  d: 1'b1};
    tbl[1] = '{m: 3'd0, v: 10'd40,   strobe: 1'b1, pn: 16'd240,  d: 1'b0};
    tbl[2] = '{m: 3'd0, v: 10'd40,   strobe: 1'b0, pn: 16'd240,  d: 1'b0};
    tbl[3] = '{m: 3'd4, v: 10'd1023, strobe: 1'b1, pn: 16'd4092, d: 1'b1};
    tbl[4] = '{m: 3'd0, v: 10'd0,    strobe: 1'b1, pn: 16'd160,  d: 1'b0};

    rst_n         = 1'b0;
    init_done     = 6'h3F;
    lock          = 1'b0;
    ack_en        = 6'h3F;
    start_seen    = '0;
    cif.cmd_valid = 1'b0;
    cif.cmd_motor = '0;
    cif.cmd_value = '0;
    #12;
    check("rst_start", start, 0);
    check("rst_pulse", {31'd0, |pulse_num}, 0);
    check("rst_dir", dir, 0);
    check("rst_mf", mf, 0);
    check("rst_err_ack", err_ack, 0);
    check("rst_err_cmd", err_cmd, 0);
    check("rst_ready", cif.cmd_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_vec(tbl[k], k);

    // Arbitration order from ptr=1, plus full-slot backpressure under lock
    run_vec('{m: 3'd1, v: 10'd10, strobe: 1'b1, pn: 16'd40, d: 1'b1}, 5);
    lock = 1'b1;
    start_seen = '0;
    send(3'd1, 10'd20);
    send(3'd3, 10'd30);
    send(3'd5, 10'd50);
    repeat (8) tick();
    check("lock_no_start", start_seen, 0);
    cif.cmd_valid = 1'b1;
    cif.cmd_motor = 3'd3;
    cif.cmd_value = 10'd35;
    #1;
`ifdef SCHED_COALESCE_EN
    check("full_slot_ready", cif.cmd_ready, 1);
`else
    check("full_slot_ready", cif.cmd_ready, 0);
`endif
    tick();
    cif.cmd_valid = 1'b0;
    grants.delete();
    lock = 1'b0;
    repeat (40) tick();
    check("rr_count", grants.size(), 3);
    check("rr_first",  grants.size() > 0 ? grants[0] : 7, 3);
    check("rr_second", grants.size() > 1 ? grants[1] : 7, 5);
    check("rr_third",  grants.size() > 2 ? grants[2] : 7, 1);
`ifdef SCHED_COALESCE_EN
    check("rr_pulse3", pn_of(3), 140);
`else
    check("rr_pulse3", pn_of(3), 120);
`endif
    check("rr_pulse5", pn_of(5), 200);
    check("rr_pulse1", pn_of(1), 40);

    // Illegal motor index is taken and dropped
    start_seen = '0;
    cif.cmd_valid = 1'b1;
    cif.cmd_motor = 3'd7;
    cif.cmd_value = 10'd99;
    #1;
    check("m7_ready", cif.cmd_ready, 1);
    tick();
    cif.cmd_valid = 1'b0;
    check("m7_err_cmd", err_cmd, 1);
    tick();
    check("m7_err_cmd_clr", err_cmd, 0);
    repeat (6) tick();
    check("m7_no_start", start_seen, 0);

    // Acknowledge timeout on motor 4 (last 1023 -> target 1000)
    ack_en[4] = 1'b0;
    grants.delete();
    send(3'd4, 10'd1000);
    wait_grant("to_grant");
    repeat (8) tick();
    check("to_early", err_ack, 0);
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        tick();
        if (err_ack[4]) got = 1'b1;
      end
      check("to_seen", got, 1);
    end
    check("to_err_ack", err_ack, 6'b010000);
    check("to_pulse", pn_of(4), 92);
    check("to_dir", dir[4], 0);
    run_vec('{m: 3'd0, v: 10'd50, strobe: 1'b1, pn: 16'd200, d: 1'b1}, 6);
    start_seen = '0;
    send(3'd4, 10'd5);
    repeat (20) tick();
    check("to_no_regrant", start_seen[4], 0);

    // Homing gate on motor 2
    init_done = 6'b111011;
    start_seen = '0;
    send(3'd2, 10'd7);
    repeat (12) tick();
    check("home_held", start_seen, 0);
    grants.delete();
    init_done = 6'h3F;
    wait_grant("home_grant");
    check("home_idx", grants.size() > 0 ? grants[0] : 7, 2);
    repeat (4) tick();
    check("home_pulse", pn_of(2), 28);

    // Asynchronous reset in WAIT_ACK
    ack_en[0] = 1'b0;
    grants.delete();
    send(3'd0, 10'd77);
    wait_grant("rst_grant");
    check("rst_pre_pulse", pn_of(0), 108);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_start", start, 0);
    check("arst_pulse", {31'd0, |pulse_num}, 0);
    check("arst_dir", dir, 0);
    check("arst_mf", mf, 0);
    check("arst_err_ack", err_ack, 0);
    check("arst_err_cmd", err_cmd, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ack_en = 6'h3F;
    tick();
    run_vec('{m: 3'd0, v: 10'd100, strobe: 1'b1, pn: 16'd400, d: 1'b1}, 7);
    e = mf;
    check("post_rst_mf_only0", e, 6'b000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
